// File: rtl/sha256_pkg.sv
// sha256_pkg: shared widths, latency constants and LOOP legality check for the SHA-256 job path
package sha256_pkg;
   localparam int SHA256_ROUNDS = 64;
   localparam int SEQ_LATENCY = 66;
   localparam int HASH_W = 256;
   localparam int STATE_W = 256;
   localparam int BLOCK_W = 512;
   function automatic bit loop_legal(input int loop);
      return loop inside {1, 2, 4, 8, 16, 32, 64};
   endfunction
endpackage

// File: rtl/sha256_tag_pipe.sv
// sha256_tag_pipe: fixed-latency {valid, tag} delay line that follows each job through the transform
// clk, reset (async, active-high), flush (sync clear of valid bits)
// in_valid/in_tag: entry inserted at the head every cycle
// out_valid/out_tag: entry leaving the tail DEPTH cycles after insertion
module sha256_tag_pipe import sha256_pkg::*; #(
   parameter int DEPTH = SEQ_LATENCY,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   output logic [TAG_W-1:0] out_tag
);
   logic [DEPTH-1:0] vld_q;
   logic [TAG_W-1:0] tag_q [DEPTH];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         vld_q <= '0;
         for (int i = 0; i < DEPTH; i++) tag_q[i] <= '0;
      end else begin
         vld_q <= flush ? '0 : {vld_q[DEPTH-2:0], in_valid};
         tag_q[0] <= in_tag;
         for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
      end
   assign out_valid = vld_q[DEPTH-1];
   assign out_tag = tag_q[DEPTH-1];
endmodule

// File: rtl/sha256_job_sequencer.sv
// sha256_job_sequencer: issues (midstate, block, tag) jobs into a folded sha256_transform and returns tagged results
// clk, reset (async, active-high); job_valid/job_ready/job_state/job_data/job_tag: job handshake
// flush: sync discard of in-flight jobs; feedback/cnt/rx_state/rx_input: transform control and operands
// tx_hash: transform result; res_valid/res_hash/res_tag: one-cycle tagged result strobe
module sha256_job_sequencer import sha256_pkg::*; #(
   parameter int LOOP = 4,
   parameter int TAG_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               job_valid,
   output logic               job_ready,
   input  logic [STATE_W-1:0] job_state,
   input  logic [BLOCK_W-1:0] job_data,
   input  logic [TAG_W-1:0]   job_tag,
   input  logic               flush,
   output logic               feedback,
   output logic [5:0]         cnt,
   output logic [STATE_W-1:0] rx_state,
   output logic [BLOCK_W-1:0] rx_input,
   input  logic [HASH_W-1:0]  tx_hash,
   output logic               res_valid,
   output logic [HASH_W-1:0]  res_hash,
   output logic [TAG_W-1:0]   res_tag
);
   if (!loop_legal(LOOP)) begin : g_bad_loop
      $error("sha256_job_sequencer: illegal LOOP %0d", LOOP);
   end
   localparam logic [5:0] LAST = 6'(LOOP - 1);
   logic [5:0] cnt_q, cnt_d;
   logic fb_q, run_q, accept, retire;
   logic [STATE_W-1:0] st_q, st_d;
   logic [BLOCK_W-1:0] in_q, in_d;
   logic [6:0] fl_q, fl_d;
   // run_q keeps job_ready low while in reset, which matters for LOOP=1 where every cycle is a slot.
   // The midstate may only change with an empty pipeline since tx_hash folds in the live rx_state.
   always_comb begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 6'd1;
      job_ready = run_q & (cnt_q == LAST) & ~flush & ((fl_q == '0) | (job_state == st_q));
      accept = job_valid & job_ready;
      st_d = accept ? job_state : st_q;
      in_d = accept ? job_data : in_q;
      fl_d = flush ? '0 : fl_q + {6'd0, accept} - {6'd0, retire};
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cnt_q <= '0;
         fb_q <= 1'b0;
         run_q <= 1'b0;
         st_q <= '0;
         in_q <= '0;
         fl_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         fb_q <= cnt_d != '0;
         run_q <= 1'b1;
         st_q <= st_d;
         in_q <= in_d;
         fl_q <= fl_d;
      end
   sha256_tag_pipe #(.DEPTH(SEQ_LATENCY), .TAG_W(TAG_W)) u_tags (
      .clk(clk),
      .reset(reset),
      .flush(flush),
      .in_valid(accept),
      .in_tag(accept ? job_tag : '0),
      .out_valid(retire),
      .out_tag(res_tag)
   );
   assign feedback = fb_q;
   assign cnt = cnt_q;
   assign rx_state = st_q;
   assign rx_input = in_q;
   assign res_valid = retire;
   assign res_hash = tx_hash;
endmodule

// File: doc/sha256_job_sequencer.md
# sha256_job_sequencer

Job-side controller for a `sha256_transform` instance: accepts (midstate, block, tag) jobs on a valid/ready handshake and drives the transform's `feedback`, `cnt`, `rx_state` and `rx_input`. It collects `tx_hash` and returns each result with its tag. It sits between the work distributor and the hashing core, and owns all issue-slot timing for any `LOOP` setting.

## Interface
- `LOOP`, 4: transform fold factor; legal values 1, 2, 4, 8, 16, 32, 64; must equal the paired transform's `LOOP`.
- `TAG_W`, 8: job tag width.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `job_valid` in 1: job offered.
- `job_ready` out 1: job accepted when both `job_valid` and `job_ready` are high at a rising edge.
- `job_state` in 256: midstate for the job.
- `job_data` in 512: message block for the job.
- `job_tag` in TAG_W: opaque tag returned with the result.
- `flush` in 1: synchronous discard of all in-flight jobs.
- `feedback` out 1: to transform.
- `cnt` out 6: to transform.
- `rx_state` out 256: to transform.
- `rx_input` out 512: to transform.
- `tx_hash` in 256: from transform.
- `res_valid` out 1: one-cycle result strobe; no backpressure.
- `res_hash` out 256: equals `tx_hash` while `res_valid` is high.
- `res_tag` out TAG_W: tag of the job whose result is presented.

## Operation
- Reset values: `cnt`=0, `feedback`=0, `rx_state`=0, `rx_input`=0, `res_valid`=0, `res_tag`=0, `job_ready`=0, in-flight count=0, tracker cleared.
- Slot counter: `cnt` increments by 1 each cycle, modulo `LOOP` (wraps from LOOP-1 to 0). For `LOOP`=1 it is stuck at 0.
- `feedback` is registered and equals (`cnt` != 0) in every cycle.
- Issue slot: `job_ready` = (`cnt` == LOOP-1) AND NOT `flush` AND midstate_ok. For `LOOP`=1 the `cnt` term is always true.
  - midstate_ok = (in-flight count == 0) OR (`job_state` == `rx_state`).
  - `tx_hash` adds the current `rx_state` at capture time, so the midstate may only change while the pipeline is empty.
- On acceptance: `rx_input`<=`job_data`, `rx_state`<=`job_state`, and the tracker enters valid=1 with `job_tag`.
- Issue slot with no acceptance: `rx_input` and `rx_state` hold, and the tracker enters valid=0 (bubble).
- In-flight count:
  - +1 on accept, -1 on retire.
  - Simultaneous accept and retire leaves it unchanged.
  - Width is 7 bits; the maximum is 64/LOOP+2, so it never saturates.
- Retire: a valid entry reaching the tracker end raises `res_valid` for exactly one cycle, with `res_tag` = its tag.
- `flush`: tracker valid bits and in-flight count clear at the next edge. No `res_valid` is produced for jobs accepted before or during the flush cycle. `cnt` keeps running.
- Reset mid-operation: all in-flight jobs are lost silently; no spurious `res_valid` after deassertion.

## Timing
- Acceptance in cycle N (handshake sampled at the edge ending N):
  - `rx_input` is valid and `feedback`=0 in cycle N+1.
  - Transform stage 0 captures at the end of N+1.
  - Final state is at the last stage after the end of N+64; `feedback`=0 in N+65.
  - `tx_hash` is captured at the end of N+65.
  - `res_valid`=1 in cycle N+66.
- Latency is 66 cycles for every legal `LOOP`.
- Throughput: one job per `LOOP` cycles. Back-to-back accepts are exactly `LOOP` cycles apart.
- `job_ready` is a function of registered state plus `job_state` and `flush` only. It never depends on `job_valid`.

## Structure
- Shared package `sha256_pkg` holds:
  - `SHA256_ROUNDS`=64.
  - `SEQ_LATENCY`=66.
  - The legal-`LOOP` check function.
  - Hash/state/block width constants (256/512).
- Sub-module `sha256_tag_pipe` is a 66-cycle delay line of {valid, tag}.
  - Synchronous clear on `flush`; async clear on `reset`.
  - Shifts every cycle.
  - The issue slot inserts at its head; other cycles insert valid=0.
- Top level holds the slot counter, issue registers, midstate check and in-flight counter.

## Test plan
- Single job, `LOOP`=4: midstate = SHA-256 IV, block = "abc" padded.
  - Accepted in cycle N → `res_valid` only in N+66.
  - `res_hash` = ba7816bf…f20015ad.
  - `res_tag`=0x5A.
- Saturation, `LOOP`=4: `job_valid` held high for 40 jobs with tags 0..39.
  - Accepts exactly every 4 cycles.
  - Results in tag order, 4 cycles apart, each matching the software model.
- Midstate change with 3 jobs in flight: `job_ready` stays 0 until the third retires, then the new midstate is accepted. Hashes for both midstates are correct.
- `flush` asserted 20 cycles after two accepts: no `res_valid` ever appears for them. A job accepted 4 cycles after the flush returns at +66.
- Reset asserted at cycle 30 of a job, released 5 cycles later: all outputs at reset values immediately, no `res_valid` within 200 cycles, and the next job completes normally.
- Sweep `LOOP` over {1, 2, 64}: 66-cycle latency holds and throughput is one job per `LOOP` cycles.
